// File: rtl/alimentador_instrucoes.sv
// Program sequencer feeding instruction words to processador_multiciclo.
// Holds a small program memory, issues one instruction per Run pulse,
// supplies the mvi immediate on the following cycle and waits for Done.
// Optional build macro WATCHDOG_EN adds a WAIT-state timeout that raises Erro.
module alimentador_instrucoes #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int PROG_DEPTH = 16,
    parameter int WD_LIMIT   = 15
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Prog_we,
    input  logic [ADDR_W-1:0] Prog_addr,
    input  logic [DATA_W-1:0] Prog_data,
    input  logic [ADDR_W:0]   Prog_len,
    input  logic              Done,
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    output logic [ADDR_W:0]   PC,
    output logic [ADDR_W:0]   Instr_count,
    output logic              Busy,
    output logic              Finished,
    output logic              Erro
);

    localparam int CNT_W = ADDR_W + 1;

    // A memory that does not exactly cover the address space would let PC
    // address words that do not exist.
    if (PROG_DEPTH != (1 << ADDR_W) || WD_LIMIT < 1) begin : g_bad_params
        $error("alimentador_instrucoes: PROG_DEPTH must equal 2**ADDR_W and WD_LIMIT must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_IMM,
        S_WAIT,
        S_FIM
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              run_q, run_d;
    logic              busy_q, busy_d;
    logic              fin_q, fin_d;
    logic [DATA_W-1:0] mem_q [PROG_DEPTH];

    logic [CNT_W-1:0]  eff_len;
    logic [CNT_W-1:0]  pc_inc;
    logic [CNT_W-1:0]  cnt_inc;
    logic              is_mvi;

`ifdef WATCHDOG_EN
    localparam int WD_W = $clog2(WD_LIMIT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              erro_q, erro_d;
`endif

    // Program memory: written only while the sequencer is not running.
    always_ff @(posedge Clock) begin
        if (Prog_we && (state_q == S_IDLE || state_q == S_FIM)) begin
            mem_q[Prog_addr] <= Prog_data;
        end
    end

    // Next-state and registered-output computation for the sequencer.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        din_d   = din_q;
`ifdef WATCHDOG_EN
        wd_d    = wd_q;
        erro_d  = erro_q;
`endif
        eff_len = (Prog_len > CNT_W'(PROG_DEPTH)) ? CNT_W'(PROG_DEPTH) : Prog_len;
        pc_inc  = pc_q + CNT_W'(1);
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        // In ISSUE din_q holds the word at pc_q, so its opcode field is valid here.
        is_mvi  = (din_q[8:6] == 3'b001);

        case (state_q)
            S_IDLE: begin
                if (Start) begin
`ifdef WATCHDOG_EN
                    erro_d = 1'b0;
`endif
                    if (eff_len != '0) begin
                        pc_d    = '0;
                        cnt_d   = '0;
                        len_d   = eff_len;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_FIM;
                    end
                end
            end
            S_ISSUE: begin
                pc_d = pc_inc;
                if (is_mvi && pc_inc < len_q) begin
                    state_d = S_IMM;
                end else begin
                    state_d = S_WAIT;
                    // An mvi whose immediate falls past the program end gets no data word.
                    if (is_mvi) din_d = '0;
                end
            end
            S_IMM: begin
                pc_d = pc_inc;
                if (Done) begin
                    cnt_d   = cnt_inc;
                    state_d = (pc_inc >= len_q) ? S_FIM : S_ISSUE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (Done) begin
                    cnt_d   = cnt_inc;
                    state_d = (pc_q >= len_q) ? S_FIM : S_ISSUE;
                end
`ifdef WATCHDOG_EN
                else if (wd_q == WD_LAST) begin
                    erro_d  = 1'b1;
                    state_d = S_FIM;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
            end
            S_FIM: begin
                if (!Start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef WATCHDOG_EN
        // Holding the counter at zero outside WAIT makes every WAIT entry start fresh.
        if (state_q != S_WAIT) wd_d = '0;
`endif

        // Outputs are registered, so they are decoded from the state being entered.
        run_d  = (state_d == S_ISSUE);
        busy_d = (state_d == S_ISSUE) || (state_d == S_IMM) || (state_d == S_WAIT);
        fin_d  = (state_d == S_FIM);
        if (state_d == S_ISSUE || state_d == S_IMM) begin
            din_d = mem_q[pc_d[ADDR_W-1:0]];
        end else if (state_d == S_IDLE || state_d == S_FIM) begin
            din_d = '0;
        end
    end

    // Sequencer state and output registers; reset aborts any program at once.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            din_q   <= '0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
`ifdef WATCHDOG_EN
            wd_q    <= '0;
            erro_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            din_q   <= din_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
`ifdef WATCHDOG_EN
            wd_q    <= wd_d;
            erro_q  <= erro_d;
`endif
        end
    end

    assign DIN         = din_q;
    assign Run         = run_q;
    assign PC          = pc_q;
    assign Instr_count = cnt_q;
    assign Busy        = busy_q;
    assign Finished    = fin_q;
`ifdef WATCHDOG_EN
    assign Erro        = erro_q;
`else
    assign Erro        = 1'b0;
`endif

endmodule

// File: tb/tb_alimentador_instrucoes.sv
// Self-checking bench for alimentador_instrucoes: directed vector table,
// hand-written corner sequences and randomized programs against a
// program-walk reference model.
module tb_alimentador_instrucoes;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          Clock = 1'b0;
    logic          Resetn = 1'b0;
    logic          Start = 1'b0;
    logic          Prog_we = 1'b0;
    logic [AW-1:0] Prog_addr = '0;
    logic [DW-1:0] Prog_data = '0;
    logic [AW:0]   Prog_len = '0;
    logic          Done = 1'b0;
    logic [DW-1:0] DIN;
    logic          Run;
    logic [AW:0]   PC;
    logic [AW:0]   Instr_count;
    logic          Busy;
    logic          Finished;
    logic          Erro;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] obs_run[$];
    logic [DW-1:0] obs_hold[$];
    logic [DW-1:0] exp_run[$];
    logic [DW-1:0] exp_hold[$];
    int            dly_q[$];

    typedef struct {
        logic [AW:0]         len;
        int                  nw;
        logic [3:0][DW-1:0]  w;
        logic [2:0][3:0]     dly;
        int                  nrun;
        logic [2:0][DW-1:0]  er;
        logic [2:0][DW-1:0]  eh;
        logic [AW:0]         ecnt;
        logic [AW:0]         epc;
    } vec_t;

    vec_t tbl[4];

    always #5 Clock = ~Clock;

    alimentador_instrucoes dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .Start       (Start),
        .Prog_we     (Prog_we),
        .Prog_addr   (Prog_addr),
        .Prog_data   (Prog_data),
        .Prog_len    (Prog_len),
        .Done        (Done),
        .DIN         (DIN),
        .Run         (Run),
        .PC          (PC),
        .Instr_count (Instr_count),
        .Busy        (Busy),
        .Finished    (Finished),
        .Erro        (Erro)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic load(input int a, input logic [DW-1:0] w);
        Prog_addr = a[AW-1:0];
        Prog_data = w;
        Prog_we   = 1'b1;
        @(negedge Clock);
        Prog_we   = 1'b0;
    endtask

    // Starts a program and plays the processor: Done is returned dly_q[i]
    // cycles after the i-th Run pulse; records issued words and the DIN value
    // seen in each Done cycle. Returns with the sequencer back in IDLE.
    task automatic execute(input logic [AW:0] len);
        int cd;
        bit fin;
        obs_run.delete();
        obs_hold.delete();
        cd  = 0;
        fin = 0;
        Prog_len = len;
        Start    = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            Done = 1'b0;
            if (Finished) begin
                fin = 1;
            end else begin
                if (Run) begin
                    obs_run.push_back(DIN);
                    check("busy_on_run", Busy, 1);
                    if (dly_q.size() > 0) cd = dly_q.pop_front();
                    else cd = 1;
                end else if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        Done = 1'b1;
                        obs_hold.push_back(DIN);
                    end
                end
                @(negedge Clock);
            end
        end
        if (!fin) check("run_timeout_finished", Finished, 1);
        check("erro_after_run", Erro, 0);
        Done = 1'b0;
        @(negedge Clock);
    endtask

    task automatic compare_obs();
        check("run_pulse_count", obs_run.size(), exp_run.size());
        check("done_count", obs_hold.size(), exp_hold.size());
        for (int i = 0; i < exp_run.size() && i < obs_run.size(); i++)
            check($sformatf("run_word[%0d]", i), obs_run[i], exp_run[i]);
        for (int i = 0; i < exp_hold.size() && i < obs_hold.size(); i++)
            check($sformatf("wait_din[%0d]", i), obs_hold[i], exp_hold[i]);
    endtask

    initial begin
        logic [DW-1:0] prog[DEPTH];
        logic [DW-1:0] hold;
        logic [AW:0]   rlen;
        int            L;
        int            a;
        int            m_cnt;
        int            m_pc;
        int            n;

        tbl[0] = '{len: 5'd2, nw: 2, w: {16'h0000, 16'h0000, 16'h0005, 16'h0040},
                   dly: {4'd0, 4'd0, 4'd1}, nrun: 1,
                   er: {16'h0000, 16'h0000, 16'h0040}, eh: {16'h0000, 16'h0000, 16'h0005},
                   ecnt: 5'd1, epc: 5'd2};
        tbl[1] = '{len: 5'd4, nw: 4, w: {16'h0081, 16'h0008, 16'h0005, 16'h0040},
                   dly: {4'd3, 4'd1, 4'd2}, nrun: 3,
                   er: {16'h0081, 16'h0008, 16'h0040}, eh: {16'h0081, 16'h0008, 16'h0005},
                   ecnt: 5'd3, epc: 5'd4};
        tbl[2] = '{len: 5'd0, nw: 0, w: '0, dly: '0, nrun: 0, er: '0, eh: '0,
                   ecnt: 5'd3, epc: 5'd4};
        tbl[3] = '{len: 5'd2, nw: 2, w: {16'h0000, 16'h0000, 16'h0040, 16'h0008},
                   dly: {4'd0, 4'd2, 4'd1}, nrun: 2,
                   er: {16'h0000, 16'h0040, 16'h0008}, eh: {16'h0000, 16'h0000, 16'h0008},
                   ecnt: 5'd2, epc: 5'd2};

        // Reset state
        repeat (2) @(negedge Clock);
        check("rst_din", DIN, 0);
        check("rst_run", Run, 0);
        check("rst_pc", PC, 0);
        check("rst_count", Instr_count, 0);
        check("rst_busy", Busy, 0);
        check("rst_finished", Finished, 0);
        check("rst_erro", Erro, 0);
        Resetn = 1'b1;
        @(negedge Clock);
        check("idle_busy", Busy, 0);

        // Directed vector table
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < tbl[t].nw; i++) load(i, tbl[t].w[i]);
            dly_q.delete();
            exp_run.delete();
            exp_hold.delete();
            for (int i = 0; i < tbl[t].nrun; i++) begin
                dly_q.push_back(int'(tbl[t].dly[i]));
                exp_run.push_back(tbl[t].er[i]);
                exp_hold.push_back(tbl[t].eh[i]);
            end
            execute(tbl[t].len);
            compare_obs();
            check($sformatf("vec%0d_count", t), Instr_count, tbl[t].ecnt);
            check($sformatf("vec%0d_pc", t), PC, tbl[t].epc);
        end

        // Empty program with Start held high stays in FIM until Start drops
        Prog_len = '0;
        Start = 1'b1;
        @(negedge Clock);
        check("len0_finished", Finished, 1);
        check("len0_run", Run, 0);
        check("len0_busy", Busy, 0);
        repeat (3) @(negedge Clock);
        check("len0_hold_finished", Finished, 1);
        check("len0_hold_run", Run, 0);
        Start = 1'b0;
        @(negedge Clock);
        check("len0_release_finished", Finished, 0);
        check("len0_pc_kept", PC, 2);
        check("len0_count_kept", Instr_count, 2);

        // Memory write while busy is ignored
        load(0, 16'h0008);
        Prog_len = 5'd1;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        check("we_busy_run", Run, 1);
        check("we_busy_din", DIN, 16'h0008);
        Prog_addr = '0;
        Prog_data = 16'h01C0;
        Prog_we   = 1'b1;
        @(negedge Clock);
        Prog_we = 1'b0;
        check("we_busy_busy", Busy, 1);
        Done = 1'b1;
        @(negedge Clock);
        Done = 1'b0;
        check("we_busy_finished", Finished, 1);
        @(negedge Clock);
        dly_q = {1};
        exp_run = {16'h0008};
        exp_hold = {16'h0008};
        execute(5'd1);
        compare_obs();

        // Asynchronous reset while waiting for Done
        Prog_len = 5'd1;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        @(negedge Clock);
        check("pre_reset_busy", Busy, 1);
        #2 Resetn = 1'b0;
        #1;
        check("async_rst_din", DIN, 0);
        check("async_rst_run", Run, 0);
        check("async_rst_pc", PC, 0);
        check("async_rst_busy", Busy, 0);
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
        check("post_reset_busy", Busy, 0);
        check("post_reset_finished", Finished, 0);
        m_cnt = 0;
        m_pc  = 0;

        // Randomized programs against the program-walk model
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                prog[i] = 16'($urandom);
                if ($urandom_range(0, 2) == 0) prog[i][8:6] = 3'b001;
                load(i, prog[i]);
            end
            rlen = 5'($urandom_range(0, 20));
            L = (int'(rlen) > DEPTH) ? DEPTH : int'(rlen);
            dly_q.delete();
            exp_run.delete();
            exp_hold.delete();
            if (L > 0) begin
                a = 0;
                m_cnt = 0;
                while (a < L) begin
                    exp_run.push_back(prog[a]);
                    dly_q.push_back($urandom_range(1, 4));
                    if (prog[a][8:6] == 3'b001) begin
                        if (a + 1 < L) begin
                            hold = prog[a + 1];
                            a += 2;
                        end else begin
                            hold = '0;
                            a += 1;
                        end
                    end else begin
                        hold = prog[a];
                        a += 1;
                    end
                    exp_hold.push_back(hold);
                    m_cnt++;
                end
                m_pc = a;
            end
            execute(rlen);
            compare_obs();
            check($sformatf("rnd%0d_count", r), Instr_count, m_cnt);
            check($sformatf("rnd%0d_pc", r), PC, m_pc);
        end

`ifdef WATCHDOG_EN
        // Watchdog: no Done ever arrives
        load(0, 16'h0008);
        Prog_len = 5'd1;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        check("wd_run", Run, 1);
        n = 0;
        while (!Finished && n < 100) begin
            @(negedge Clock);
            n++;
        end
        check("wd_cycles_to_fim", n, 16);
        check("wd_erro", Erro, 1);
        check("wd_din", DIN, 0);
        @(negedge Clock);
        check("wd_erro_sticky", Erro, 1);
        dly_q = {1};
        exp_run = {16'h0008};
        exp_hold = {16'h0008};
        execute(5'd1);
        compare_obs();
`else
        n = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule

// File: doc/alimentador_instrucoes.md
Name: alimentador_instrucoes

Overview:
- Program sequencer that drives the instruction side of the multicycle processor. It is the initiator; the processor is the responder.
- Holds a small instruction/immediate memory, loaded through a write port while the sequencer is idle.
- Issues each instruction on DIN with a one-cycle Run pulse, supplies the mvi immediate word on the following cycle, and waits for Done before advancing.
- Sits between the testbench/board top and processador_multiciclo (DIN, Run, Done).

Parameters:
- DATA_W, 16, width of DIN and of each memory word.
- ADDR_W, 4, program address width.
- PROG_DEPTH, 16, number of memory words (must equal 2**ADDR_W).
- WD_LIMIT, 15, watchdog limit in cycles spent in WAIT (used only when the watchdog is compiled in).

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- Start  input  1  level; begins program execution from address 0.
- Prog_we  input  1  memory write enable; honoured only in IDLE or FIM.
- Prog_addr  input  ADDR_W  memory write address.
- Prog_data  input  DATA_W  memory write data.
- Prog_len  input  ADDR_W+1  number of words in the program (instructions plus immediates).
- Done  input  1  from the processor; the current instruction has completed.
- DIN  output  DATA_W  instruction or immediate word to the processor.
- Run  output  1  one-cycle issue strobe.
- PC  output  ADDR_W+1  next word address.
- Instr_count  output  ADDR_W+1  number of instructions retired.
- Busy  output  1  high in ISSUE, IMM and WAIT.
- Finished  output  1  high in FIM.
- Erro  output  1  watchdog timeout flag; tied to 0 when the watchdog is compiled out.

Behaviour:
- Reset is asynchronous (Resetn=0): DIN=0, Run=0, PC=0, Instr_count=0, Busy=0, Finished=0, Erro=0, state=IDLE. Memory contents are not cleared. Reset mid-program aborts immediately.
- Instruction format is DIN[8:0] = III XXX YYY. Opcode 001 (mvi) takes two words; every other opcode takes one word.
- Effective length is L = min(Prog_len, PROG_DEPTH). Prog_len is sampled only on the IDLE->ISSUE transition.
- Memory is registered-write and combinational-read. A write with Prog_we=1 outside IDLE/FIM is ignored.
- IDLE: Run=0, DIN=0.
  - Start=1 and L>0: PC<=0, Instr_count<=0, Erro<=0, go to ISSUE.
  - Start=1 and L=0: go to FIM.
- ISSUE (exactly 1 cycle): DIN=mem[PC], Run=1, PC<=PC+1.
  - If DIN[8:6]==001 and PC+1<L: go to IMM.
  - Otherwise go to WAIT. An mvi whose immediate would lie beyond L is issued with no immediate word, and DIN is driven to 0 during WAIT.
- IMM (1 cycle): DIN=mem[PC], Run=0, PC<=PC+1.
  - Done=1 in this cycle is accepted; mvi completes on T1. Acceptance is handled as in WAIT.
  - Otherwise go to WAIT.
- WAIT: DIN holds the last driven word, Run=0.
  - On Done=1: Instr_count<=Instr_count+1; go to FIM if PC>=L, else ISSUE.
  - Done is ignored outside IMM/WAIT.
  - Minimum issue interval is therefore 2 cycles (1-word instruction with Done on the next cycle).
- FIM: Finished=1, DIN=0, Run=0. Go to IDLE when Start=0. Start held high does not restart execution.
- Start is ignored while Busy. Deasserting Start mid-program does not abort.
- PC never wraps: its width is ADDR_W+1 and execution stops at L<=PROG_DEPTH.
- Instr_count saturates at all ones.

Optional Feature:
- Macro WATCHDOG_EN.
  - Defined: a cycle counter clears on entry to WAIT and increments each WAIT cycle. When it reaches WD_LIMIT with no Done, the block sets Erro=1 (sticky until the next Start from IDLE), drives Run=0 and DIN=0, and goes to FIM.
  - Undefined: no counter is built, Erro is constant 0, and WAIT waits forever.

Test Plan:
- Reset during WAIT: Resetn low asynchronously -> DIN=0, Run=0, PC=0, Busy=0 within the same cycle; after release the block is in IDLE.
- Load mem[0]=0x0040 (mvi R0), mem[1]=0x0005, Prog_len=2; Start=1; Done pulsed in the IMM cycle -> cycle1 DIN=0x0040 Run=1; cycle2 DIN=0x0005 Run=0; then FIM, Finished=1, Instr_count=1, PC=2.
- Load 0x0040, 0x0005, 0x0008 (mv R1,R0), 0x0081 (add R0,R1), Prog_len=4; Done returned 1 cycle after IMM, 1 cycle after the mv issue, 3 cycles after the add issue -> exactly three Run pulses carrying 0x0040, 0x0008, 0x0081; final Instr_count=3.
- Prog_len=0, Start=1 -> straight to FIM, no Run pulse. Start held high -> remains in FIM. Start=0 -> IDLE.
- Prog_we=1 to address 0 while Busy -> mem[0] unchanged; verified by rerunning the program and checking DIN on the Run cycle.
- WATCHDOG_EN with WD_LIMIT=15: issue 0x0008 and never assert Done -> Erro=1 and state FIM after 15 WAIT cycles. Next Start clears Erro.
